// File: rtl/parking_zone_tracker_pkg.sv
// Shared types for the parking zone tracker: zone index and gate FSM encoding.
package parking_pkg;
  localparam int NUM_ZONES = 4;

  typedef logic [1:0] zone_t;

  typedef enum logic {
    GATE_IDLE = 1'b0,
    GATE_OPEN = 1'b1
  } gate_state_t;
endpackage

// File: rtl/zone_slot_counter.sv
// Free-space counter for one zone: saturates at CAPACITY, never wraps below 0.
module zone_slot_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       full
);

  // A simultaneous inc and dec cancel, leaving the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'(CAPACITY);
    end else if (inc && !dec && (count != 3'(CAPACITY))) begin
      count <= count + 3'd1;
    end else if (dec && !inc && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign full = (count == 3'd0);

endmodule

// File: rtl/parking_zone_tracker.sv
// Entry-gate handshake and per-zone free-space tracking feeding the display digits.
module parking_zone_tracker
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 4,
  parameter int GATE_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic [1:0] entry_zone,
  input  logic       gate_passed,
  input  logic       exit_pulse,
  input  logic [1:0] exit_zone,
  output logic       gate_open,
  output logic       reject,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] zone_full
);

  localparam int TW = $clog2(GATE_TIMEOUT);

  gate_state_t          state, state_next;
  logic [TW-1:0]        timer, timer_next;
  zone_t                held_zone, held_next;
  logic                 entry_sensor_d;
  logic                 req;
  logic                 reject_next;
  logic [NUM_ZONES-1:0] inc, dec, full;
  logic [2:0]           count [NUM_ZONES];

  // Edge register resets high so a sensor already covered at release is not a request.
  assign req = entry_sensor & ~entry_sensor_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= GATE_IDLE;
      timer          <= '0;
      held_zone      <= '0;
      reject         <= 1'b0;
      entry_sensor_d <= 1'b1;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      held_zone      <= held_next;
      reject         <= reject_next;
      entry_sensor_d <= entry_sensor;
    end
  end

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    held_next   = held_zone;
    reject_next = 1'b0;
    dec         = '0;
    case (state)
      GATE_IDLE: begin
        if (req) begin
          if (full[entry_zone]) begin
            reject_next = 1'b1;
          end else begin
            held_next  = entry_zone;
            timer_next = '0;
            state_next = GATE_OPEN;
          end
        end
      end
      GATE_OPEN: begin
        timer_next = timer + 1'b1;
        if (req) reject_next = 1'b1;
        // Passage wins over a timeout expiring in the same cycle.
        if (gate_passed) begin
          dec[held_zone] = 1'b1;
          state_next     = GATE_IDLE;
        end else if (timer == TW'(GATE_TIMEOUT - 1)) begin
          state_next = GATE_IDLE;
        end
      end
      default: state_next = GATE_IDLE;
    endcase
  end

  always_comb begin
    inc = '0;
    if (exit_pulse) inc[exit_zone] = 1'b1;
  end

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    zone_slot_counter #(
      .CAPACITY(CAPACITY)
    ) u_counter (
      .clk  (clk),
      .reset(reset),
      .inc  (inc[z]),
      .dec  (dec[z]),
      .count(count[z]),
      .full (full[z])
    );
  end

  assign gate_open = (state == GATE_OPEN);
  assign digit_0   = {1'b0, count[0]};
  assign digit_1   = {1'b0, count[1]};
  assign digit_2   = {1'b0, count[2]};
  assign digit_3   = {1'b0, count[3]};
  assign zone_full = full;

endmodule

// File: tb/tb_parking_zone_tracker.sv
// Bench for parking_zone_tracker: directed scenarios plus random traffic against a behavioural model.
module tb_parking_zone_tracker;
  localparam int CAP = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_sensor;
  logic [1:0] entry_zone;
  logic       gate_passed;
  logic       exit_pulse;
  logic [1:0] exit_zone;
  logic       gate_open;
  logic       reject;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic [3:0] zone_full;

  int n_checks = 0;
  int n_errors = 0;

  parking_zone_tracker #(
    .CAPACITY(CAP),
    .GATE_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_sensor(entry_sensor),
    .entry_zone  (entry_zone),
    .gate_passed (gate_passed),
    .exit_pulse  (exit_pulse),
    .exit_zone   (exit_zone),
    .gate_open   (gate_open),
    .reject      (reject),
    .digit_0     (digit_0),
    .digit_1     (digit_1),
    .digit_2     (digit_2),
    .digit_3     (digit_3),
    .zone_full   (zone_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: free spaces per zone, whether the gate is up, and how long it has been up.
  int m_free [4];
  bit m_open, m_reject, m_prev, armed;
  int m_held, m_elapsed;

  initial begin
    armed = 0;
    m_open = 0;
    m_reject = 0;
    m_prev = 1;
    m_held = 0;
    m_elapsed = 0;
    for (int z = 0; z < 4; z++) m_free[z] = CAP;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int z = 0; z < 4; z++) m_free[z] = CAP;
      m_open = 0;
      m_reject = 0;
      m_prev = 1;
      m_elapsed = 0;
      armed = 1;
    end else begin
      bit req;
      int dz;
      int nv;
      req = entry_sensor && !m_prev;
      m_prev = entry_sensor;
      dz = -1;
      m_reject = 0;
      if (!m_open) begin
        if (req) begin
          if (m_free[entry_zone] == 0) m_reject = 1;
          else begin
            m_open = 1;
            m_held = int'(entry_zone);
            m_elapsed = 0;
          end
        end
      end else begin
        if (req) m_reject = 1;
        m_elapsed++;
        if (gate_passed) begin
          dz = m_held;
          m_open = 0;
        end else if (m_elapsed == TMO) begin
          m_open = 0;
        end
      end
      for (int z = 0; z < 4; z++) begin
        nv = m_free[z];
        if (exit_pulse && int'(exit_zone) == z) nv++;
        if (dz == z) nv--;
        if (nv > CAP) nv = CAP;
        if (nv < 0) nv = 0;
        m_free[z] = nv;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [3:0] fz;
      for (int z = 0; z < 4; z++) fz[z] = (m_free[z] == 0);
      chk("gate_open", 32'(gate_open), 32'(m_open));
      chk("reject", 32'(reject), 32'(m_reject));
      chk("digit_0", 32'(digit_0), 32'(m_free[0]));
      chk("digit_1", 32'(digit_1), 32'(m_free[1]));
      chk("digit_2", 32'(digit_2), 32'(m_free[2]));
      chk("digit_3", 32'(digit_3), 32'(m_free[3]));
      chk("zone_full", 32'(zone_full), 32'(fz));
    end
  end

  task automatic drive(input bit r, input bit s, input logic [1:0] z,
                       input bit gp, input bit ex, input logic [1:0] xz);
    reset        = r;
    entry_sensor = s;
    entry_zone   = z;
    gate_passed  = gp;
    exit_pulse   = ex;
    exit_zone    = xz;
    @(negedge clk);
  endtask

  task automatic pass_into(input logic [1:0] z);
    drive(0, 1, z, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int open_cycles;
    bit s;
    reset = 1; entry_sensor = 0; entry_zone = 0;
    gate_passed = 0; exit_pulse = 0; exit_zone = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    chk("reset_gate_open", 32'(gate_open), 0);
    chk("reset_digit_1", 32'(digit_1), 4);
    chk("reset_zone_full", 32'(zone_full), 0);
    drive(0, 0, 0, 0, 0, 0);

    // Accept and pass into zone 2
    drive(0, 1, 2, 0, 0, 0);
    chk("accept_gate_open", 32'(gate_open), 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("pass_gate_closed", 32'(gate_open), 0);
    chk("pass_digit_2", 32'(digit_2), 3);

    // Fill zone 0 then reject
    for (int i = 0; i < 4; i++) pass_into(0);
    chk("fill_digit_0", 32'(digit_0), 0);
    chk("fill_zone_full", 32'(zone_full), 1);
    drive(0, 1, 0, 0, 0, 0);
    chk("full_reject", 32'(reject), 1);
    chk("full_gate_stays", 32'(gate_open), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("reject_one_cycle", 32'(reject), 0);

    // Timeout on zone 1
    drive(0, 1, 1, 0, 0, 0);
    open_cycles = 0;
    for (int i = 0; i < 20 && gate_open; i++) begin
      open_cycles++;
      drive(0, 0, 0, 0, 0, 0);
    end
    chk("timeout_cycles", 32'(open_cycles), TMO);
    chk("timeout_digit_1", 32'(digit_1), 4);

    // Passage in the cycle the timeout expires still counts
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("expiry_pass_digit_1", 32'(digit_1), 3);

    // Busy reject and simultaneous entry/exit on zone 3
    pass_into(3);
    pass_into(3);
    chk("zone3_at_2", 32'(digit_3), 2);
    drive(0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("busy_reject", 32'(reject), 1);
    chk("busy_gate_still_open", 32'(gate_open), 1);
    drive(0, 0, 0, 1, 1, 3);
    chk("simul_digit_3", 32'(digit_3), 2);
    chk("simul_gate_closed", 32'(gate_open), 0);

    // Saturation on zone 1
    drive(0, 0, 0, 0, 1, 1);
    chk("exit_digit_1", 32'(digit_1), 4);
    drive(0, 0, 0, 0, 1, 1);
    chk("saturate_digit_1", 32'(digit_1), 4);

    // Reset mid-open, then sensor held across reset
    drive(0, 1, 2, 0, 0, 0);
    chk("pre_reset_open", 32'(gate_open), 1);
    drive(1, 1, 0, 1, 0, 0);
    chk("reset_mid_open_gate", 32'(gate_open), 0);
    chk("reset_mid_open_digit_0", 32'(digit_0), 4);
    chk("reset_mid_open_digit_2", 32'(digit_2), 4);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
    chk("held_sensor_no_open", 32'(gate_open), 0);
    chk("held_sensor_no_reject", 32'(reject), 0);

    // Random traffic
    s = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      drive($urandom_range(0, 299) == 0, s, 2'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
            2'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
